occupancy_counter: RTL and testbench
====================================

# occupancy_counter

Parametrised multi-lane occupancy counter: the next generation of the single-lane two-sensor counter. Each of LANES lanes has a sensor pair {b,a}; a per-lane FSM decodes the full gray sequence as an entry (increment) or exit (decrement), and a shared saturating counter tracks occupancy against CAPACITY. Inputs are synchronised and glitch-filtered. Illegal sensor jumps are flagged per lane. The block sits between the raw sensor pins and the display/status logic.

## Interface
- LANES, 2: number of independent sensor-pair lanes (1..8).
- CNT_W, 8: occupancy counter width.
- CAPACITY, 200: saturation limit; 1 <= CAPACITY <= 2^CNT_W-1.
- FILTER, 2: consecutive stable cycles required before a synchronised sensor value is accepted (>=1).
- clk  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- sensor  in  2*LANES  lane i is {b,a} = sensor[2i+1:2i]; asynchronous to clk.
- clr_sticky  in  1  clears overflow/underflow.
- count  out  CNT_W  current occupancy.
- full  out  1  count == CAPACITY.
- empty  out  1  count == 0.
- inc_pulse  out  LANES  one-cycle pulse per completed entry.
- dec_pulse  out  LANES  one-cycle pulse per completed exit.
- err_pulse  out  LANES  one-cycle pulse on entering ERR.
- overflow  out  1  sticky: an increment was dropped at CAPACITY.
- underflow  out  1  sticky: a decrement was dropped at 0.
- debug_state  out  3*LANES  lane i FSM state at [3i+2:3i].

## Operation
- Per lane: 2-flop synchroniser, then filter. Filtered value takes the stage-2 value once stage-2 has held it for FILTER consecutive edges.
- FSM states (debug encoding): IDLE=0, IN1=1 ({b,a}=01), IN2=2 (11), IN3=3 (10), OUT1=4 (10), OUT2=5 (11), OUT3=6 (01), ERR=7.
- IDLE: 01->IN1; 10->OUT1; 11->ERR; 00 holds.
- Entry path IN1->IN2->IN3 on each forward gray step. From IN3, 00 -> IDLE with inc_pulse.
- Exit path OUT1->OUT2->OUT3 likewise. From OUT3, 00 -> IDLE with dec_pulse.
- In any path state:
  - Unchanged input holds the state.
  - A one-step backward gray move returns to the previous state (IN1/OUT1 with 00 -> IDLE); no count change.
  - A two-bit change -> ERR with err_pulse.
- ERR holds until filtered input is 00, then -> IDLE. No count change.
- Aggregation each cycle: net = popcount(inc_pulse) - popcount(dec_pulse), signed. count_next = clamp(count + net, 0, CAPACITY).
  - Clamped high sets overflow; clamped low sets underflow.
  - Opposing lanes cancel: +1 and -1 in the same cycle leave count unchanged, with no flag.
- clr_sticky clears both sticky flags. If a flag set and clr_sticky occur in the same cycle, set wins.
- full and empty are registered together with count.

## Timing
- Reset (asynchronous assert, release on the next clk edge):
  - Synchroniser and filter stages = 00; all FSMs IDLE; count = 0; empty = 1.
  - full, overflow, underflow, all pulses = 0; debug_state = 0.
  - Reset mid-sequence discards any partial transit.
- Latency: sensor stable before edge k -> stage1 at k, stage2 at k+1, filtered at k+1+FILTER.
  - FSM state and pulses at edge E = k+2+FILTER.
  - count, full, empty and flags at E+1.
  - With FILTER=2: pulse 4 cycles after the input change, count 5 cycles after.
- A stage-2 value held for fewer than FILTER edges is ignored entirely.
- Pulses are exactly one cycle wide. Each lane produces at most one pulse per cycle.

## Test plan
- LANES=1: lane0 drives 00,01,11,10,00, each held 10 cycles -> inc_pulse[0] high for 1 cycle; debug walks 1,2,3,0; count 0->1 one cycle after the pulse; empty falls.
- From count=1, exit sequence 00,10,11,01,00 -> dec_pulse[0], count=0, empty=1. Repeat the exit -> dec_pulse fires, count stays 0, underflow=1. Assert clr_sticky -> underflow=0.
- FILTER=2: one-cycle 01 glitch on lane0 -> debug stays 0, no pulses. Sequence 00,01,00 (back out) -> debug 1 then 0, count unchanged.
- 00->11 directly on lane0 -> err_pulse[0], debug=7, held while input is 11/10/01; returns to 0 on 00; count unchanged.
- LANES=2, CAPACITY=3, count=2, both lanes complete entries in the same cycle -> count=3, full=1, overflow=1. Then lane0 entry and lane1 exit in the same cycle -> count stays 3, no new flag.
- Assert reset_n=0 mid-entry (debug=2) -> all outputs at reset values immediately. After release, finishing the old sequence (10,00) produces no inc_pulse.

Source files
------------

// File: rtl/occupancy_counter.sv
// Multi-lane occupancy counter: per-lane sync/filter and gray-sequence FSM
// feeding a shared saturating count with sticky overflow/underflow flags.
module occupancy_counter #(
  parameter int LANES    = 2,
  parameter int CNT_W    = 8,
  parameter int CAPACITY = 200,
  parameter int FILTER   = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [2*LANES-1:0]   sensor,
  input  logic                 clr_sticky,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic [LANES-1:0]     inc_pulse,
  output logic [LANES-1:0]     dec_pulse,
  output logic [LANES-1:0]     err_pulse,
  output logic                 overflow,
  output logic                 underflow,
  output logic [3*LANES-1:0]   debug_state
);

  localparam int FW = $clog2(FILTER + 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    IN1  = 3'd1,
    IN2  = 3'd2,
    IN3  = 3'd3,
    OUT1 = 3'd4,
    OUT2 = 3'd5,
    OUT3 = 3'd6,
    ERR  = 3'd7
  } state_t;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [1:0]    s1, s2, held, filt;
    logic [1:0]    cur, fwd, bck;
    logic [FW-1:0] run, run_n;
    state_t        st, st_f, st_b;
    logic          inc, dec, err;

    // run counts consecutive edges at which stage 2 kept its value
    always_comb begin
      if (s2 != held)
        run_n = FW'(1);
      else if (run == FW'(FILTER))
        run_n = run;
      else
        run_n = run + FW'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1   <= '0;
        s2   <= '0;
        held <= '0;
        run  <= '0;
        filt <= '0;
      end else begin
        s1   <= sensor[2*i +: 2];
        s2   <= s1;
        held <= s2;
        run  <= run_n;
        if (run_n >= FW'(FILTER))
          filt <= s2;
      end
    end

    // hold value, forward/backward gray neighbours of each path state
    always_comb begin
      cur  = 2'b00;
      fwd  = 2'b00;
      bck  = 2'b00;
      st_f = IDLE;
      st_b = IDLE;
      unique case (st)
        IN1: begin
          cur = 2'b01; fwd = 2'b11; bck = 2'b00;
          st_f = IN2;  st_b = IDLE;
        end
        IN2: begin
          cur = 2'b11; fwd = 2'b10; bck = 2'b01;
          st_f = IN3;  st_b = IN1;
        end
        IN3: begin
          cur = 2'b10; fwd = 2'b00; bck = 2'b11;
          st_f = IDLE; st_b = IN2;
        end
        OUT1: begin
          cur = 2'b10; fwd = 2'b11; bck = 2'b00;
          st_f = OUT2; st_b = IDLE;
        end
        OUT2: begin
          cur = 2'b11; fwd = 2'b01; bck = 2'b10;
          st_f = OUT3; st_b = OUT1;
        end
        OUT3: begin
          cur = 2'b01; fwd = 2'b00; bck = 2'b11;
          st_f = IDLE; st_b = OUT2;
        end
        default: ;
      endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        st  <= IDLE;
        inc <= 1'b0;
        dec <= 1'b0;
        err <= 1'b0;
      end else begin
        inc <= 1'b0;
        dec <= 1'b0;
        err <= 1'b0;
        unique case (1'b1)
          (st == IDLE): begin
            unique case (filt)
              2'b01: st <= IN1;
              2'b10: st <= OUT1;
              2'b11: begin
                st  <= ERR;
                err <= 1'b1;
              end
              default: ;
            endcase
          end
          (st == ERR): begin
            if (filt == 2'b00)
              st <= IDLE;
          end
          default: begin
            if (filt == fwd) begin
              st  <= st_f;
              inc <= (st == IN3);
              dec <= (st == OUT3);
            end else if (filt == bck) begin
              st <= st_b;
            end else if (filt != cur) begin
              st  <= ERR;
              err <= 1'b1;
            end
          end
        endcase
      end
    end

    assign inc_pulse[i]          = inc;
    assign dec_pulse[i]          = dec;
    assign err_pulse[i]          = err;
    assign debug_state[3*i +: 3] = st;
  end

  int             n_inc, n_dec, sum;
  logic [CNT_W-1:0] cnt_n;
  logic           ovf_set, unf_set;

  always_comb begin
    n_inc   = 0;
    n_dec   = 0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      n_inc = n_inc + (inc_pulse[l] ? 1 : 0);
      n_dec = n_dec + (dec_pulse[l] ? 1 : 0);
    end
    sum = int'(count) + n_inc - n_dec;
    if (sum > CAPACITY) begin
      cnt_n   = CNT_W'(CAPACITY);
      ovf_set = 1'b1;
    end else if (sum < 0) begin
      cnt_n   = '0;
      unf_set = 1'b1;
    end else begin
      cnt_n = CNT_W'(sum);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      count     <= cnt_n;
      full      <= (cnt_n == CNT_W'(CAPACITY));
      empty     <= (cnt_n == '0);
      overflow  <= ovf_set | (overflow & ~clr_sticky);
      underflow <= unf_set | (underflow & ~clr_sticky);
    end
  end

endmodule

// File: tb/tb_occupancy_counter.sv
// Bench for occupancy_counter: directed scenarios plus a randomized run
// against a gray-position reference model (LANES=2, CAPACITY=3, FILTER=2).
module tb_occupancy_counter;

  localparam logic [7:0] ENT = 8'b01_11_10_00;
  localparam logic [7:0] EXI = 8'b10_11_01_00;
  localparam logic [7:0] NOP = 8'b00_00_00_00;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] sensor = '0;
  logic       clr_sticky = 1'b0;
  logic [7:0] count;
  logic       full, empty, overflow, underflow;
  logic [1:0] inc_pulse, dec_pulse, err_pulse;
  logic [5:0] debug_state;

  int errors = 0;
  int checks = 0;
  int inc_tot[2] = '{0, 0};
  int dec_tot[2] = '{0, 0};
  int err_tot[2] = '{0, 0};

  occupancy_counter #(
    .LANES(2), .CNT_W(8), .CAPACITY(3), .FILTER(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .sensor(sensor),
    .clr_sticky(clr_sticky), .count(count), .full(full),
    .empty(empty), .inc_pulse(inc_pulse), .dec_pulse(dec_pulse),
    .err_pulse(err_pulse), .overflow(overflow),
    .underflow(underflow), .debug_state(debug_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int l = 0; l < 2; l++) begin
      inc_tot[l] += int'(inc_pulse[l]);
      dec_tot[l] += int'(dec_pulse[l]);
      err_tot[l] += int'(err_pulse[l]);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sensor = '0;
    clr_sticky = 1'b0;
    tick(2);
    reset_n = 1'b1;
    tick(6);
  endtask

  task automatic seq(input logic [7:0] s0, input logic [7:0] s1);
    for (int j = 0; j < 4; j++) begin
      sensor = {s1[7-2*j -: 2], s0[7-2*j -: 2]};
      tick(10);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({count, full, empty, overflow, underflow} !== {8'd0, 4'b0100}) begin
      errors++;
      $display("FAIL reset_status: got cnt=%0d f/e/o/u=%b want cnt=0 f/e/o/u=0100",
               count, {full, empty, overflow, underflow});
    end
    checks++;
    if ({inc_pulse, dec_pulse, err_pulse, debug_state} !== 12'd0) begin
      errors++;
      $display("FAIL reset_lanes: got pulses=%b dbg=%h want all zero",
               {inc_pulse, dec_pulse, err_pulse}, debug_state);
    end
  endtask

  task automatic test_entry();
    int s;
    logic [2:0] want [3] = '{3'd1, 3'd2, 3'd3};
    logic [1:0] vals [3] = '{2'b01, 2'b11, 2'b10};
    s = inc_tot[0];
    for (int j = 0; j < 3; j++) begin
      sensor = {2'b00, vals[j]};
      tick(10);
      checks++;
      if (debug_state[2:0] !== want[j]) begin
        errors++;
        $display("FAIL entry_walk%0d: got %0d want %0d", j, debug_state[2:0], want[j]);
      end
    end
    sensor = 4'b0000;
    for (int i = 1; i <= 6; i++) begin
      tick(1);
      if (i == 4) begin
        checks++;
        if (inc_pulse !== 2'b00) begin
          errors++;
          $display("FAIL entry_early: got inc=%b want 00 at edge 4", inc_pulse);
        end
      end
      if (i == 5) begin
        checks++;
        if ({inc_pulse, count, debug_state[2:0]} !== {2'b01, 8'd0, 3'd0}) begin
          errors++;
          $display("FAIL entry_pulse: got inc=%b cnt=%0d dbg=%0d want 01/0/0",
                   inc_pulse, count, debug_state[2:0]);
        end
      end
      if (i == 6) begin
        checks++;
        if ({count, empty, inc_pulse} !== {8'd1, 1'b0, 2'b00}) begin
          errors++;
          $display("FAIL entry_count: got cnt=%0d empty=%b inc=%b want 1/0/00",
                   count, empty, inc_pulse);
        end
      end
    end
    tick(4);
    checks++;
    if (inc_tot[0] - s !== 1) begin
      errors++;
      $display("FAIL entry_width: got %0d pulse cycles want 1", inc_tot[0] - s);
    end
  endtask

  task automatic test_exit();
    int s;
    s = dec_tot[0];
    seq(EXI, NOP);
    checks++;
    if ({count, empty, underflow, dec_tot[0] - s} !== {8'd1 - 8'd1, 2'b10, 32'd1}) begin
      errors++;
      $display("FAIL exit_first: got cnt=%0d empty=%b unf=%b dec=%0d want 0/1/0/1",
               count, empty, underflow, dec_tot[0] - s);
    end
    seq(EXI, NOP);
    checks++;
    if ({count, empty, underflow, dec_tot[0] - s} !== {8'd0, 2'b11, 32'd2}) begin
      errors++;
      $display("FAIL exit_underflow: got cnt=%0d empty=%b unf=%b dec=%0d want 0/1/1/2",
               count, empty, underflow, dec_tot[0] - s);
    end
    clr_sticky = 1'b1;
    tick(1);
    clr_sticky = 1'b0;
    tick(1);
    checks++;
    if (underflow !== 1'b0) begin
      errors++;
      $display("FAIL exit_clear: got unf=%b want 0", underflow);
    end
  endtask

  task automatic test_glitch();
    int bad;
    int s;
    bad = 0;
    s = inc_tot[0] + dec_tot[0] + err_tot[0];
    sensor = 4'b0001;
    tick(1);
    sensor = 4'b0000;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      if (debug_state[2:0] !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0 || inc_tot[0] + dec_tot[0] + err_tot[0] != s) begin
      errors++;
      $display("FAIL glitch: got %0d non-idle cycles, %0d pulses want 0/0",
               bad, inc_tot[0] + dec_tot[0] + err_tot[0] - s);
    end
    sensor = 4'b0001;
    tick(10);
    checks++;
    if (debug_state[2:0] !== 3'd1) begin
      errors++;
      $display("FAIL backout_in1: got %0d want 1", debug_state[2:0]);
    end
    sensor = 4'b0000;
    tick(10);
    checks++;
    if ({debug_state[2:0], count, inc_tot[0] + dec_tot[0] + err_tot[0] - s} !==
        {3'd0, 8'd0, 32'd0}) begin
      errors++;
      $display("FAIL backout_idle: got dbg=%0d cnt=%0d want 0/0",
               debug_state[2:0], count);
    end
  endtask

  task automatic test_error();
    int s;
    logic [1:0] vals [4] = '{2'b11, 2'b10, 2'b01, 2'b11};
    s = err_tot[0];
    for (int j = 0; j < 4; j++) begin
      sensor = {2'b00, vals[j]};
      tick(10);
      checks++;
      if (debug_state[2:0] !== 3'd7) begin
        errors++;
        $display("FAIL err_hold%0d: got %0d want 7", j, debug_state[2:0]);
      end
    end
    sensor = 4'b0000;
    tick(10);
    checks++;
    if ({debug_state[2:0], count, err_tot[0] - s} !== {3'd0, 8'd0, 32'd1}) begin
      errors++;
      $display("FAIL err_exit: got dbg=%0d cnt=%0d errp=%0d want 0/0/1",
               debug_state[2:0], count, err_tot[0] - s);
    end
  endtask

  task automatic test_back_to_back();
    seq(ENT, NOP);
    seq(ENT, NOP);
    checks++;
    if ({count, full} !== {8'd2, 1'b0}) begin
      errors++;
      $display("FAIL b2b_pre: got cnt=%0d full=%b want 2/0", count, full);
    end
    seq(ENT, ENT);
    checks++;
    if ({count, full, overflow} !== {8'd3, 2'b11}) begin
      errors++;
      $display("FAIL b2b_overflow: got cnt=%0d full=%b ovf=%b want 3/1/1",
               count, full, overflow);
    end
    clr_sticky = 1'b1;
    tick(1);
    clr_sticky = 1'b0;
    seq(ENT, EXI);
    checks++;
    if ({count, full, overflow, underflow} !== {8'd3, 3'b100}) begin
      errors++;
      $display("FAIL b2b_cancel: got cnt=%0d full=%b ovf=%b unf=%b want 3/1/0/0",
               count, full, overflow, underflow);
    end
  endtask

  task automatic test_reset_mid();
    int s;
    sensor = 4'b0001;
    tick(10);
    sensor = 4'b0011;
    tick(10);
    checks++;
    if (debug_state[2:0] !== 3'd2) begin
      errors++;
      $display("FAIL mid_pre: got %0d want 2", debug_state[2:0]);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if ({count, full, empty, overflow, underflow, debug_state,
         inc_pulse, dec_pulse, err_pulse} !== {8'd0, 4'b0100, 6'd0, 6'd0}) begin
      errors++;
      $display("FAIL mid_reset: got cnt=%0d f/e/o/u=%b dbg=%h want 0/0100/0",
               count, {full, empty, overflow, underflow}, debug_state);
    end
    tick(1);
    reset_n = 1'b1;
    s = inc_tot[0];
    tick(10);
    sensor = 4'b0010;
    tick(10);
    sensor = 4'b0000;
    tick(10);
    checks++;
    if ({inc_tot[0] - s, count} !== {32'd0, 8'd0}) begin
      errors++;
      $display("FAIL mid_discard: got inc=%0d cnt=%0d want 0/0",
               inc_tot[0] - s, count);
    end
  endtask

  function automatic int rpos(input logic [1:0] v);
    case (v)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ring(input int idx);
    case (idx % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  // model lane: dir 0 idle, +1 entering, -1 exiting, 2 error;
  // pos = distance along that direction's gray ring
  task automatic test_random();
    int mdir[2], mpos[2], mcount, net, n, r;
    bit mov, mun, clr;
    int ei[2], ed[2], ee[2], si[2], sd[2], se[2];
    logic [1:0] v[2];
    logic [5:0] edbg;
    do_reset();
    mdir = '{0, 0};
    mpos = '{0, 0};
    mcount = 0;
    mov = 0;
    mun = 0;
    v = '{2'b00, 2'b00};
    for (int step = 0; step < 60; step++) begin
      for (int l = 0; l < 2; l++) begin
        r = $urandom_range(0, 7);
        if (r < 2) v[l] = 2'($urandom);
        else if (r < 5) v[l] = ring(rpos(v[l]) + 1);
        else if (r < 7) v[l] = ring(rpos(v[l]) + 3);
        si[l] = inc_tot[l];
        sd[l] = dec_tot[l];
        se[l] = err_tot[l];
      end
      clr = ($urandom_range(0, 3) == 0);
      sensor = {v[1], v[0]};
      if (clr) begin
        clr_sticky = 1'b1;
        tick(1);
        clr_sticky = 1'b0;
        tick(9);
        mov = 0;
        mun = 0;
      end else begin
        tick(10);
      end
      net = 0;
      for (int l = 0; l < 2; l++) begin
        ei[l] = 0;
        ed[l] = 0;
        ee[l] = 0;
        if (mdir[l] == 2) begin
          if (v[l] == 2'b00) mdir[l] = 0;
        end else if (mdir[l] == 0) begin
          if (v[l] == 2'b01) begin mdir[l] = 1; mpos[l] = 1; end
          else if (v[l] == 2'b10) begin mdir[l] = -1; mpos[l] = 1; end
          else if (v[l] == 2'b11) begin mdir[l] = 2; ee[l] = 1; end
        end else begin
          n = (mdir[l] == 1) ? rpos(v[l]) : (4 - rpos(v[l])) % 4;
          if (n == mpos[l]) begin
          end else if (mpos[l] == 3 && n == 0) begin
            if (mdir[l] == 1) ei[l] = 1;
            else ed[l] = 1;
            mdir[l] = 0;
          end else if (n == mpos[l] + 1 || n == mpos[l] - 1) begin
            mpos[l] = n;
            if (n == 0) mdir[l] = 0;
          end else begin
            mdir[l] = 2;
            ee[l] = 1;
          end
        end
        net += ei[l] - ed[l];
      end
      mcount += net;
      if (mcount > 3) begin mcount = 3; mov = 1; end
      if (mcount < 0) begin mcount = 0; mun = 1; end
      for (int l = 0; l < 2; l++) begin
        if (mdir[l] == 0) edbg[3*l +: 3] = 3'd0;
        else if (mdir[l] == 2) edbg[3*l +: 3] = 3'd7;
        else if (mdir[l] == 1) edbg[3*l +: 3] = 3'(mpos[l]);
        else edbg[3*l +: 3] = 3'(mpos[l] + 3);
      end
      checks++;
      if ({count, full, empty, overflow, underflow, debug_state} !==
          {8'(mcount), mcount == 3, mcount == 0, mov, mun, edbg}) begin
        errors++;
        $display("FAIL rand_state%0d: got cnt=%0d f/e/o/u=%b dbg=%h want cnt=%0d f/e/o/u=%b dbg=%h",
                 step, count, {full, empty, overflow, underflow}, debug_state,
                 mcount, {mcount == 3, mcount == 0, mov, mun}, edbg);
      end
      for (int l = 0; l < 2; l++) begin
        checks++;
        if (inc_tot[l] - si[l] != ei[l] || dec_tot[l] - sd[l] != ed[l] ||
            err_tot[l] - se[l] != ee[l]) begin
          errors++;
          $display("FAIL rand_pulses%0d lane%0d: got i/d/e=%0d/%0d/%0d want %0d/%0d/%0d",
                   step, l, inc_tot[l] - si[l], dec_tot[l] - sd[l],
                   err_tot[l] - se[l], ei[l], ed[l], ee[l]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_entry();
    test_exit();
    test_glitch();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
